// File: rtl/greater_than_4bit_gate.sv
// ---------------------------------------------------------------------------
// greater_than_4bit_gate
//
// Gate-level 4-bit unsigned magnitude comparator built from two 2-bit slice
// cells. The combinational gt/eq outputs have zero latency. Registered copies
// gt_q/eq_q follow them with one clock of latency.
//
// Ports
//   clk    in   1  system clock, rising edge
//   rst_n  in   1  asynchronous active-low reset (clears gt_q/eq_q only)
//   a      in   4  operand A, unsigned
//   b      in   4  operand B, unsigned
//   gt     out  1  combinational, 1 iff a > b
//   eq     out  1  combinational, 1 iff a == b
//   gt_q   out  1  gt registered on clk
//   eq_q   out  1  eq registered on clk
//
// a < b is signalled by gt = 0 and eq = 0; gt and eq are never both 1.
// ---------------------------------------------------------------------------
module greater_than_4bit_gate (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       gt,
    output logic       eq,
    output logic       gt_q,
    output logic       eq_q
);

    // Result of one 2-bit slice compare.
    typedef struct packed {
        logic gt;
        logic eq;
    } slice_t;

    // 2-bit slice cell as plain sum-of-products; no relational operators, so
    // the netlist maps one-to-one onto the gate-level description.
    function automatic slice_t cmp2(input logic [1:0] x, input logic [1:0] y);
        slice_t r;
        r.gt = (x[1] & ~y[1])
             | (x[0] & ~y[1] & ~y[0])
             | (x[1] &  x[0] & ~y[0]);
        r.eq = (x[1] ~^ y[1]) & (x[0] ~^ y[0]);
        return r;
    endfunction

    slice_t hi;
    slice_t lo;

    assign hi = cmp2(a[3:2], b[3:2]);
    assign lo = cmp2(a[1:0], b[1:0]);

    // The low slice only matters when the high slices tie.
    assign gt = hi.gt | (hi.eq & lo.gt);
    assign eq = hi.eq & lo.eq;

    // Pipeline copies. The reset is in the sensitivity list, so asserting
    // rst_n clears the flops at once without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gt_q <= 1'b0;
            eq_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments in clocked blocks, so every flop
            // samples the pre-edge value regardless of statement order.
            gt_q <= gt;
            eq_q <= eq;
        end
    end

endmodule

// File: tb/tb_greater_than_4bit_gate.sv
// ---------------------------------------------------------------------------
// tb_greater_than_4bit_gate
//
// Self-checking bench for greater_than_4bit_gate. Combinational outputs are
// compared directly after each input change. Registered outputs go through a
// scoreboard: the stimulus pushes the expected gt_q/eq_q for the coming edge
// and an independent monitor pops and compares just after each rising edge.
// Expected values come from plain integer comparison of a and b.
// ---------------------------------------------------------------------------
module tb_greater_than_4bit_gate;

    typedef struct packed {
        logic gt;
        logic eq;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic       gt;
    logic       eq;
    logic       gt_q;
    logic       eq_q;

    int   total;
    int   bad;
    exp_t exp_q[$];
    exp_t mon_e;

    greater_than_4bit_gate dut (
        .clk  (clk),
        .rst_n(rst_n),
        .a    (a),
        .b    (b),
        .gt   (gt),
        .eq   (eq),
        .gt_q (gt_q),
        .eq_q (eq_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic actual, input logic expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s a=%0d b=%0d got=%b want=%b t=%0t",
                     name, a, b, actual, expected, $time);
        end
    endtask

    // Reference model: plain unsigned integer comparison.
    function automatic exp_t model(input int x, input int y);
        exp_t r;
        r.gt = (x > y);
        r.eq = (x == y);
        return r;
    endfunction

    // Drive one pair at a falling edge, check the combinational outputs, and
    // queue the expectation for the registered outputs at the next edge.
    task automatic apply(input int x, input int y, input bit show);
        exp_t e;
        @(negedge clk);
        a = 4'(x);
        b = 4'(y);
        e = model(x, y);
        exp_q.push_back(e);
        #1;
        check("gt", gt, e.gt);
        check("eq", eq, e.eq);
        if (show) $display("%0d %0d %0d", a, b, gt);
    endtask

    // Wait (bounded) for the monitor to consume every queued expectation.
    task automatic drain();
        for (int i = 0; i < 8; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
            #2;
        end
        check("scoreboard_drain", exp_q.size() == 0, 1'b1);
    endtask

    // Monitor: registered outputs are valid just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("gt_q", gt_q, mon_e.gt);
            check("eq_q", eq_q, mon_e.eq);
        end
    end

    // Watchdog so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    // Directed corner pairs: {a, b}.
    int corner_a[7] = '{15, 0, 0, 15, 6, 5, 8};
    int corner_b[7] = '{0, 15, 0, 15, 5, 6, 7};

    initial begin
        total = 0;
        bad   = 0;
        a     = 4'd0;
        b     = 4'd0;
        rst_n = 1'b1;

        // Reset state: an explicit falling edge on rst_n, held over two clocks.
        #2 rst_n = 1'b0;
        #1;
        check("reset_gt_q", gt_q, 1'b0);
        check("reset_eq_q", eq_q, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold_gt_q", gt_q, 1'b0);
        check("reset_hold_eq_q", eq_q, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Exhaustive sweep of all 256 pairs.
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                apply(i, j, 1'b1);

        // Boundary and slice-carry corners.
        for (int k = 0; k < 7; k++)
            apply(corner_a[k], corner_b[k], 1'b0);

        // Randomized traffic.
        for (int k = 0; k < 200; k++)
            apply(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'b0);

        drain();

        // Register latency: new result visible after edge N, not before.
        @(negedge clk);
        a = 4'd3; b = 4'd9;
        @(negedge clk);
        a = 4'd9; b = 4'd3;
        #1;
        check("latency_before_edge_n", gt_q, 1'b0);
        check("latency_comb_gt", gt, 1'b1);
        @(posedge clk);
        #1;
        check("latency_after_edge_n", gt_q, 1'b1);
        @(negedge clk);
        a = 4'd3; b = 4'd9;
        #1;
        check("latency_before_edge_n1", gt_q, 1'b1);
        @(posedge clk);
        #1;
        check("latency_after_edge_n1", gt_q, 1'b0);

        // Async reset between edges while gt_q is 1.
        @(negedge clk);
        a = 4'd9; b = 4'd3;
        @(posedge clk);
        #1;
        check("pre_reset_gt_q", gt_q, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_gt_q", gt_q, 1'b0);
        check("async_reset_eq_q", eq_q, 1'b0);
        check("async_reset_comb_gt", gt, 1'b1);
        @(posedge clk);
        #1;
        check("reset_held_gt_q", gt_q, 1'b0);
        check("reset_held_comb_gt", gt, 1'b1);

        // Reset release with a == b: eq_q rises only at the next edge.
        @(negedge clk);
        a = 4'd7; b = 4'd7;
        rst_n = 1'b1;
        #1;
        check("release_before_edge_eq_q", eq_q, 1'b0);
        check("release_comb_eq", eq, 1'b1);
        @(posedge clk);
        #1;
        check("release_after_edge_eq_q", eq_q, 1'b1);
        check("release_after_edge_gt_q", gt_q, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
